// File: rtl/sipo_deser_if.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deser_if
//  Description : Bundle of the serial input, flush, and parallel-output
//                handshake signals of the SIPO deserializer.
//                master : upstream bit source / downstream word consumer
//                slave  : the deserializer itself
//  Signals     : in, enable, flush, out_ready  (toward deserializer)
//                out[SIZE], out_valid, done, busy, overrun, parity_err
//                                             (from deserializer)
//  Revision    : 1.0  initial release
// ============================================================================
interface sipo_deser_if #(
    parameter int SIZE = 8
);
    logic            in;
    logic            enable;
    logic            flush;
    logic            out_ready;
    logic [SIZE-1:0] out;
    logic            out_valid;
    logic            done;
    logic            busy;
    logic            overrun;
    logic            parity_err;

    modport master (
        output in, enable, flush, out_ready,
        input  out, out_valid, done, busy, overrun, parity_err
    );

    modport slave (
        input  in, enable, flush, out_ready,
        output out, out_valid, done, busy, overrun, parity_err
    );
endinterface
`default_nettype wire

// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deser
//  Description : Serial-in parallel-out deserializer. Samples one bit per
//                enabled clock, assembles SIZE-bit words in LSB-first
//                (SHIFT_DIR=0) or MSB-first (SHIFT_DIR=1) order, and holds
//                each finished word behind a valid/ready handshake. An
//                overwrite of an unconsumed word pulses overrun.
//  Optional    : define SIPO_PARITY_EN to append one even-parity bit to each
//                frame; parity_err then reports a parity mismatch and holds
//                with out. Without it parity_err is tied low.
//  Ports       : clk        rising-edge clock
//                reset      synchronous active-high reset
//                bus        sipo_deser_if.slave (serial in, flush, output
//                           word handshake and status flags)
//  Revision    : 1.0  initial release
// ============================================================================
module sipo_deser #(
    parameter int SIZE      = 8,
    parameter int SHIFT_DIR = 0
) (
    input  logic           clk,
    input  logic           reset,
    sipo_deser_if.slave    bus
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME = SIZE + 1;
`else
    localparam int FRAME = SIZE;
`endif
    localparam int             CW     = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [CW-1:0]  c_LAST = CW'(FRAME - 1);

    logic [CW-1:0]   bit_count_q, bit_count_d;
    logic [SIZE-1:0] shreg_q,     shreg_d;
    logic [SIZE-1:0] out_q,       out_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q,      done_d;
    logic            busy_q,      busy_d;
    logic            overrun_q,   overrun_d;

    logic [SIZE-1:0] w_shreg_ins;
    logic            w_last;
    logic            w_complete;

    // Shift register with the current serial bit dropped into its slot.
    // With parity the final frame position is the parity bit; its count
    // equals SIZE and matches no slot, so nothing is stored for it.
    always_comb begin
        w_shreg_ins = shreg_q;
        for (int k = 0; k < SIZE; k++) begin
            if (SHIFT_DIR == 0) begin
                if (int'(bit_count_q) == k) w_shreg_ins[k] = bus.in;
            end else begin
                if (int'(bit_count_q) == SIZE - 1 - k) w_shreg_ins[k] = bus.in;
            end
        end
    end

    assign w_last     = (bit_count_q == c_LAST);
    assign w_complete = bus.enable & ~bus.flush & w_last;

    always_comb begin
        bit_count_d = bit_count_q;
        shreg_d     = shreg_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overrun_d   = 1'b0;

        if (bus.flush) begin
            // Flush drops any bit presented in the same cycle.
            bit_count_d = '0;
            busy_d      = 1'b0;
            shreg_d     = '0;
        end else if (bus.enable) begin
            if (w_last) begin
                bit_count_d = '0;
                busy_d      = 1'b0;
                shreg_d     = '0;
                out_d       = w_shreg_ins;
                out_valid_d = 1'b1;
                done_d      = 1'b1;
                // Consumer taking the old word this same cycle avoids loss.
                overrun_d   = out_valid_q & ~bus.out_ready;
            end else begin
                shreg_d     = w_shreg_ins;
                bit_count_d = bit_count_q + CW'(1);
                busy_d      = 1'b1;
            end
        end

        if (!w_complete && out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_count_q <= '0;
            shreg_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            bit_count_q <= bit_count_d;
            shreg_q     <= shreg_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SIPO_PARITY_EN
    logic parity_err_q, parity_err_d;

    // At completion shreg_q already holds every data bit and bus.in is the
    // parity bit; even parity means the XOR of all of them is zero.
    always_comb begin
        parity_err_d = parity_err_q;
        if (w_complete) parity_err_d = (^shreg_q) ^ bus.in;
    end

    always_ff @(posedge clk) begin
        if (reset) parity_err_q <= 1'b0;
        else       parity_err_q <= parity_err_d;
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_deser
//  Description : Self-checking bench for sipo_deser. Two instances (LSB-first
//                and MSB-first) share one stimulus stream and are compared
//                every cycle against a queue-based frame model, plus
//                table-driven words and directed corner sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sipo_deser;
    localparam int SIZE = 8;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = SIZE + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = SIZE;
    localparam bit PAR   = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic t_in  = 1'b0;
    logic t_en  = 1'b0;
    logic t_fl  = 1'b0;
    logic t_rdy = 1'b0;

    always #5 clk = ~clk;

    sipo_deser_if #(.SIZE(SIZE)) bus0 ();
    sipo_deser_if #(.SIZE(SIZE)) bus1 ();

    assign bus0.in = t_in;  assign bus0.enable = t_en;
    assign bus0.flush = t_fl; assign bus0.out_ready = t_rdy;
    assign bus1.in = t_in;  assign bus1.enable = t_en;
    assign bus1.flush = t_fl; assign bus1.out_ready = t_rdy;

    sipo_deser #(.SIZE(SIZE), .SHIFT_DIR(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    sipo_deser #(.SIZE(SIZE), .SHIFT_DIR(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    bit             mq[$];         // bits of the frame in progress, in arrival order
    logic [SIZE-1:0] m_out0 = '0, m_out1 = '0;
    logic m_val = 0, m_done = 0, m_busy = 0, m_ov = 0, m_perr = 0;

    task automatic model_update();
        bit complete;
        bit x;
        complete = 0;
        m_done = 0;
        m_ov   = 0;
        if (reset) begin
            mq.delete();
            m_out0 = '0; m_out1 = '0;
            m_val = 0; m_busy = 0; m_perr = 0;
        end else begin
            if (t_fl) mq.delete();
            else if (t_en) begin
                mq.push_back(t_in);
                if (mq.size() == FRAME) complete = 1;
            end
            if (complete) begin
                x = 0;
                for (int i = 0; i < FRAME; i++) x ^= mq[i];
                for (int i = 0; i < SIZE; i++) begin
                    m_out0[i]          = mq[i];
                    m_out1[SIZE-1-i]   = mq[i];
                end
                if (PAR) m_perr = x;
                m_ov   = m_val && !t_rdy;
                m_val  = 1;
                m_done = 1;
                mq.delete();
            end else if (m_val && t_rdy) begin
                m_val = 0;
            end
            m_busy = (mq.size() > 0);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("cyc_dut0", {19'd0, bus0.out, bus0.out_valid, bus0.done, bus0.busy, bus0.overrun, bus0.parity_err},
                          {19'd0, m_out0, m_val, m_done, m_busy, m_ov, m_perr});
        check("cyc_dut1", {19'd0, bus1.out, bus1.out_valid, bus1.done, bus1.busy, bus1.overrun, bus1.parity_err},
                          {19'd0, m_out1, m_val, m_done, m_busy, m_ov, m_perr});
    endtask

    task automatic send_bit(input logic b);
        t_en = 1; t_in = b;
        step();
        t_en = 0;
    endtask

    // Full frame: SIZE data bits (bit 0 first) then the parity bit if enabled.
    // out_ready is low except on the final bit, where it takes rdy_last.
    task automatic send_frame(input logic [SIZE-1:0] w, input logic pbit, input logic rdy_last);
        for (int i = 0; i < FRAME; i++) begin
            t_rdy = (i == FRAME - 1) ? rdy_last : 1'b0;
            send_bit((i < SIZE) ? w[i] : pbit);
        end
        t_rdy = 0;
    endtask

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;
    vec_t tbl[8];

    initial begin
        tbl[0] = '{8'h4D, 8'h4D, 8'hB2};
        tbl[1] = '{8'hA5, 8'hA5, 8'hA5};
        tbl[2] = '{8'h3C, 8'h3C, 8'h3C};
        tbl[3] = '{8'h11, 8'h11, 8'h88};
        tbl[4] = '{8'h22, 8'h22, 8'h44};
        tbl[5] = '{8'hFF, 8'hFF, 8'hFF};
        tbl[6] = '{8'h03, 8'h03, 8'hC0};
        tbl[7] = '{8'h01, 8'h01, 8'h80};

        // Reset state
        reset = 1;
        step(); step();
        check("reset_out",  {24'd0, bus0.out}, 32'd0);
        check("reset_flags", {27'd0, bus0.out_valid, bus0.done, bus0.busy, bus0.overrun, bus0.parity_err}, 32'd0);
        reset = 0;
        step();

        // Test 1/2: 1,0,1,1,0,0,1,0 -> 4D LSB-first, B2 MSB-first
        send_frame(8'h4D, ^8'h4D, 1'b0);
        check("t1_out_lsb", {24'd0, bus0.out}, 32'h4D);
        check("t2_out_msb", {24'd0, bus1.out}, 32'hB2);
        check("t1_done",    {31'd0, bus0.done}, 32'd1);
        check("t1_busy_end", {31'd0, bus0.busy}, 32'd0);
        step();
        check("t1_done_1cyc", {31'd0, bus0.done}, 32'd0);
        t_rdy = 1; step(); t_rdy = 0;
        check("t1_consumed", {31'd0, bus0.out_valid}, 32'd0);
        check("t1_out_held", {24'd0, bus0.out}, 32'h4D);

        // Table-driven words, each completing with out_ready high
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].word, ^tbl[i].word, 1'b1);
            check("tbl_lsb", {24'd0, bus0.out}, {24'd0, tbl[i].exp0});
            check("tbl_msb", {24'd0, bus1.out}, {24'd0, tbl[i].exp1});
            check("tbl_ov",  {31'd0, bus0.overrun}, 32'd0);
        end
        t_rdy = 1; step(); t_rdy = 0;

        // Test 3: stall mid-word, A5 LSB-first
        for (int i = 0; i < 4; i++) send_bit(tbl[1].word[i]);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_stall_busy", {31'd0, bus0.busy}, 32'd1);
        end
        for (int i = 4; i < 8; i++) send_bit(tbl[1].word[i]);
        if (PAR) send_bit(^tbl[1].word);
        check("t3_out", {24'd0, bus0.out}, 32'hA5);

        // Test 4: flush with simultaneous enable, then 3C
        t_rdy = 1; step(); t_rdy = 0;
        send_bit(1); send_bit(1); send_bit(1);
        t_fl = 1; t_en = 1; t_in = 1;
        step();
        t_fl = 0; t_en = 0;
        check("t4_flush_busy", {31'd0, bus0.busy}, 32'd0);
        check("t4_flush_done", {31'd0, bus0.done}, 32'd0);
        send_frame(8'h3C, ^8'h3C, 1'b0);
        check("t4_out", {24'd0, bus0.out}, 32'h3C);

        // Test 5: overrun, then replacement accepted on the completion cycle
        t_rdy = 1; step(); t_rdy = 0;
        send_frame(8'h11, ^8'h11, 1'b0);
        send_frame(8'h22, ^8'h22, 1'b0);
        check("t5_out",  {24'd0, bus0.out}, 32'h22);
        check("t5_ov",   {31'd0, bus0.overrun}, 32'd1);
        step();
        check("t5_ov_1cyc", {31'd0, bus0.overrun}, 32'd0);
        send_frame(8'h33, ^8'h33, 1'b1);
        check("t5_ov_rdy", {31'd0, bus0.overrun}, 32'd0);
        check("t5_valid",  {31'd0, bus0.out_valid}, 32'd1);

        // Test 6: reset after 5 bits, then FF
        for (int i = 0; i < 5; i++) send_bit(1);
        reset = 1; step(); reset = 0;
        check("t6_rst_out", {24'd0, bus0.out}, 32'd0);
        check("t6_rst_flags", {27'd0, bus0.out_valid, bus0.done, bus0.busy, bus0.overrun, bus0.parity_err}, 32'd0);
        for (int i = 0; i < SIZE - 1; i++) send_bit(1);
        check("t6_no_early_valid", {31'd0, bus0.out_valid}, 32'd0);
        send_bit(1);
        if (PAR) send_bit(0);
        check("t6_out", {24'd0, bus0.out}, 32'hFF);

`ifdef SIPO_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1);
        check("par_err1", {31'd0, bus0.parity_err}, 32'd1);
        step();
        check("par_hold", {31'd0, bus0.parity_err}, 32'd1);
        send_frame(8'h03, 1'b0, 1'b1);
        check("par_err0", {31'd0, bus0.parity_err}, 32'd0);
`endif

        // Randomized stream against the model
        for (int n = 0; n < 600; n++) begin
            t_in  = 1'($urandom);
            t_en  = ($urandom_range(0, 3) != 0);
            t_fl  = ($urandom_range(0, 24) == 0);
            t_rdy = 1'($urandom);
            reset = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 0; t_en = 0; t_fl = 0; t_rdy = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Serial-in parallel-out deserializer, the receive-side counterpart of the team's PISO serializer.
- Samples one serial bit per enabled clock and assembles SIZE-bit words.
- Bit ordering is selectable to match the serializer's SHIFT_DIR.
- Presents each completed word on a held output register with a valid/ready handshake toward the downstream consumer, and flags overruns.

Parameters:
SIZE, 8, data word width in bits (>=1).
SHIFT_DIR, 0, 0 = first received bit lands in out[0] (LSB first); 1 = first received bit lands in out[SIZE-1] (MSB first).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
in  input  1  serial data bit, sampled when enable=1.
enable  input  1  serial bit valid this cycle.
flush  input  1  abort the partial word in progress.
out_ready  input  1  downstream accepts the held word this cycle.
out  output  SIZE  assembled parallel word.
out_valid  output  1  out holds an unconsumed word.
done  output  1  one-cycle pulse when a word completes.
busy  output  1  partial word in progress.
overrun  output  1  one-cycle pulse: an unconsumed word was overwritten.
parity_err  output  1  see Optional Feature.

Behaviour:
- Reset (synchronous, while reset=1 at clk edge):
  - out=0, out_valid=0, done=0, busy=0, overrun=0, parity_err=0.
  - bit_count=0; shift register=0.
  - Reset overrides all other inputs, including mid-word; partial data is discarded.
- bit_count width is max($clog2(FRAME),1), where FRAME=SIZE (SIZE+1 with parity).
- Bit placement: on an enable=1 cycle, in is written to shreg[bit_count] (SHIFT_DIR=0) or shreg[SIZE-1-bit_count] (SHIFT_DIR=1).
- Accept cycle, enable=1 and bit_count<FRAME-1: bit stored, bit_count+1, busy<=1.
- Completion cycle, enable=1 and bit_count==FRAME-1:
  - bit_count<=0 and busy<=0.
  - Next cycle: out = assembled word including the final bit, out_valid=1, done=1 for exactly one cycle.
  - Latency: 1 clock from the last bit's sampling edge to out_valid.
- enable=0 mid-word: stall. bit_count and shreg hold, busy stays 1, done=0.
- flush=1: bit_count<=0, busy<=0, shreg cleared.
  - flush wins over a simultaneous enable; that bit is dropped and no completion occurs.
  - flush does not affect out/out_valid.
- Handshake:
  - out_valid=1 and out_ready=1 with no completion: out_valid<=0 next cycle; out holds its last value.
  - out is stable while out_valid=1 and out_ready=0.
- Completion while out_valid=1:
  - out_ready=1 same cycle: new word replaces out, out_valid stays 1, overrun=0.
  - out_ready=0: new word overwrites out, out_valid stays 1, overrun=1 for one cycle.
- done and overrun are never asserted for more than one cycle per completion.
- SIZE=1: every enabled bit is a completion cycle; busy never asserts.

Optional Feature:
SIPO_PARITY_EN
- Defined:
  - FRAME=SIZE+1; the final enabled bit of each frame is an even-parity bit over the SIZE data bits and is not stored in out.
  - parity_err is valid alongside done and holds with out: 1 if XOR(data bits, parity bit)=1.
  - parity_err updates only on completion.
- Undefined: FRAME=SIZE; parity_err is tied to 0; the port remains present.

Test Plan:
1. SIZE=8, SHIFT_DIR=0; feed 1,0,1,1,0,0,1,0 on 8 consecutive enable cycles -> one cycle after the 8th bit: out=8'h4D, out_valid=1, done pulse 1 cycle, busy high during bits 2-8 then 0.
2. Same sequence with SHIFT_DIR=1 -> out=8'hB2.
3. Feed 4 bits, hold enable=0 for 5 cycles, feed the remaining 4 bits of 8'hA5 (LSB first) -> out=8'hA5; busy stays 1 throughout the stall.
4. Feed 3 bits, flush=1 with enable=1, then a full 8'h3C -> out=8'h3C, no spurious done before it.
5. Leave 8'h11 unconsumed (out_ready=0), complete 8'h22 -> out=8'h22, overrun pulse 1 cycle. Repeat with out_ready=1 on the completion cycle -> overrun=0, out_valid stays 1.
6. Assert reset after 5 bits, then feed 8'hFF -> all outputs 0 after reset; out=8'hFF only after 8 new bits. With SIPO_PARITY_EN: data 8'h03, parity 1 -> parity_err=1; parity 0 -> parity_err=0.
